// File: rtl/decoder_scan_sequencer.sv
// decoder_scan_sequencer
// Scans a 2-bit select (A = sel[0], B = sel[1]) and an enable E for a
// downstream 2-to-4 decoder. Each unmasked slot is enabled for PRESCALE
// cycles. The sequencer runs freely while run=1, or shows one slot per
// step_req while run=0.
//
// Build option: define SCAN_BLANK_EN to insert BLANK_CYCLES disabled
// cycles between run-mode slots. With it undefined, E stays high across
// consecutive run-mode slots and BLANK_CYCLES is not used.
//
// frame_done pulses on any slot advance (run or step) whose new select
// is not above the old one. The initial load from IDLE into run mode is
// a fresh start rather than an advance, so it never pulses frame_done.
//
// state_dbg exposes the FSM state (0 IDLE, 1 ACTIVE, 2 BLANK).

module decoder_scan_sequencer #(
    parameter int PRESCALE     = 4,
    parameter int BLANK_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic       step_req,
    input  logic [3:0] mask,
    output logic       A,
    output logic       B,
    output logic       E,
    output logic       step_ack,
    output logic       frame_done,
    output logic [1:0] state_dbg
);

    // Reject illegal parameter values at elaboration time.
    if (PRESCALE < 1 || PRESCALE > 255) begin : g_bad_prescale
        $error("decoder_scan_sequencer: PRESCALE must be 1..255");
    end
    if (BLANK_CYCLES < 1 || BLANK_CYCLES > 255) begin : g_bad_blank
        $error("decoder_scan_sequencer: BLANK_CYCLES must be 1..255");
    end

    localparam logic [7:0] LAST_ACTIVE = 8'(PRESCALE - 1);
`ifdef SCAN_BLANK_EN
    localparam logic [7:0] LAST_BLANK  = 8'(BLANK_CYCLES - 1);
`endif

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        BLANK  = 2'd2
    } state_t;

    state_t     state, state_n;
    logic [1:0] sel, sel_n;
    logic [7:0] cnt, cnt_n;
    logic       step_mode, step_mode_n;
    logic       e_q, e_n;
    logic       ack_q, ack_n;
    logic       fd_q, fd_n;

`ifdef SCAN_BLANK_EN
    // Slot chosen at the end of ACTIVE, applied when E rises again.
    logic [1:0] pend_sel, pend_sel_n;
    logic       pend_wrap, pend_wrap_n;
`endif

    // Search result: {found, slot}.
    logic [2:0] adv_res;
    logic [2:0] first_res;
    logic [1:0] adv_sel;
    logic       adv_ok;
    logic [1:0] first_sel;
    logic       first_ok;

    // First unmasked slot in the order base+1, base+2, base+3, base.
    // Iterating from the farthest candidate down lets the nearest win.
    function automatic logic [2:0] search(input logic [1:0] base,
                                          input logic [3:0] m);
        logic [2:0] r;
        logic [1:0] c;
        r = {1'b0, base};
        for (int i = 4; i >= 1; i--) begin
            c = base + i[1:0];
            if (!m[c]) begin
                r = {1'b1, c};
            end
        end
        return r;
    endfunction

    // Slot search: next(sel) for advances, upward-from-0 for a run start.
    always_comb begin
        adv_res   = search(sel, mask);
        first_res = search(2'd3, mask);
        adv_ok    = adv_res[2];
        adv_sel   = adv_res[1:0];
        first_ok  = first_res[2];
        first_sel = first_res[1:0];
    end

    // Next-state and next-output logic.
    always_comb begin
        state_n     = state;
        sel_n       = sel;
        cnt_n       = cnt;
        step_mode_n = step_mode;
        ack_n       = 1'b0;
        fd_n        = 1'b0;
`ifdef SCAN_BLANK_EN
        pend_sel_n  = pend_sel;
        pend_wrap_n = pend_wrap;
`endif
        case (state)
            IDLE: begin
                if (run) begin
                    // run wins over step_req; stay idle if all slots masked
                    if (first_ok) begin
                        state_n     = ACTIVE;
                        sel_n       = first_sel;
                        cnt_n       = 8'd0;
                        step_mode_n = 1'b0;
                    end
                end else if (step_req && adv_ok) begin
                    state_n     = ACTIVE;
                    sel_n       = adv_sel;
                    fd_n        = (adv_sel <= sel);
                    cnt_n       = 8'd0;
                    step_mode_n = 1'b1;
                end
            end

            ACTIVE: begin
                if (cnt == LAST_ACTIVE) begin
                    cnt_n = 8'd0;
                    if (step_mode) begin
                        state_n = IDLE;
                        ack_n   = 1'b1;
                    end else if (run && adv_ok) begin
`ifdef SCAN_BLANK_EN
                        state_n     = BLANK;
                        pend_sel_n  = adv_sel;
                        pend_wrap_n = (adv_sel <= sel);
`else
                        // back-to-back slots: E never drops
                        sel_n = adv_sel;
                        fd_n  = (adv_sel <= sel);
`endif
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end

`ifdef SCAN_BLANK_EN
            BLANK: begin
                if (cnt == LAST_BLANK) begin
                    state_n = ACTIVE;
                    sel_n   = pend_sel;
                    fd_n    = pend_wrap;
                    cnt_n   = 8'd0;
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end
`endif

            default: begin
                state_n = IDLE;
                cnt_n   = 8'd0;
            end
        endcase

        e_n = (state_n == ACTIVE);
    end

    // State and registered outputs; reset forces everything idle at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sel       <= 2'd0;
            cnt       <= 8'd0;
            step_mode <= 1'b0;
            e_q       <= 1'b0;
            ack_q     <= 1'b0;
            fd_q      <= 1'b0;
        end else begin
            state     <= state_n;
            sel       <= sel_n;
            cnt       <= cnt_n;
            step_mode <= step_mode_n;
            e_q       <= e_n;
            ack_q     <= ack_n;
            fd_q      <= fd_n;
        end
    end

`ifdef SCAN_BLANK_EN
    // Pending slot held across BLANK.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_sel  <= 2'd0;
            pend_wrap <= 1'b0;
        end else begin
            pend_sel  <= pend_sel_n;
            pend_wrap <= pend_wrap_n;
        end
    end
`endif

    assign A          = sel[0];
    assign B          = sel[1];
    assign E          = e_q;
    assign step_ack   = ack_q;
    assign frame_done = fd_q;
    assign state_dbg  = state;

endmodule

// File: tb/tb_decoder_scan_sequencer.sv
// Bench for decoder_scan_sequencer (PRESCALE=4, BLANK_CYCLES=1).
// Literal step-mode vectors, a reference model over a segment table,
// an asynchronous reset check and a frame period check.
// Output word compared each cycle: {E, B, A, step_ack, frame_done}.

`timescale 1ns/1ps

module tb_decoder_scan_sequencer;

    localparam int PRESCALE     = 4;
    localparam int BLANK_CYCLES = 1;
`ifdef SCAN_BLANK_EN
    localparam int GAP = BLANK_CYCLES;
`else
    localparam int GAP = 0;
`endif
    localparam int FRAME = 4 * (PRESCALE + GAP);

    // ---------------- clock / reset / DUT ----------------
    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       run      = 1'b0;
    logic       step_req = 1'b0;
    logic [3:0] mask     = 4'b0000;
    logic       A, B, E, step_ack, frame_done;
    logic [1:0] state_dbg;

    always #5 clk = ~clk;

    decoder_scan_sequencer #(
        .PRESCALE     (PRESCALE),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .step_req   (step_req),
        .mask       (mask),
        .A          (A),
        .B          (B),
        .E          (E),
        .step_ack   (step_ack),
        .frame_done (frame_done),
        .state_dbg  (state_dbg)
    );

    // ---------------- scoreboard ----------------
    int         n_vec = 0;
    int         n_err = 0;
    logic [4:0] exp_q[$];

    task automatic check(input string name, input logic [7:0] act,
                         input logic [7:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // ---------------- reference model ----------------
    localparam int M_IDLE = 0, M_ACT = 1, M_BLANK = 2;
    int         m_st;
    int         m_cnt;
    logic [1:0] m_sel;
    logic [1:0] m_pend;
    bit         m_step;
    bit         m_ack;
    bit         m_fd;

    task automatic model_reset();
        m_st = M_IDLE; m_cnt = 0; m_sel = 2'd0; m_pend = 2'd0;
        m_step = 0; m_ack = 0; m_fd = 0;
    endtask

    // Walk the ring starting 'from' steps past base; first open slot wins.
    task automatic find_slot(input logic [1:0] base, input int from,
                             input logic [3:0] m, output logic [1:0] slot,
                             output bit ok);
        logic [1:0] c;
        ok = 0;
        slot = base;
        for (int k = from; k < from + 4; k++) begin
            c = 2'((int'(base) + k) % 4);
            if (m[c] == 1'b0) begin
                slot = c;
                ok = 1;
                break;
            end
        end
    endtask

    task automatic model_step(input logic r, input logic s, input logic [3:0] m);
        logic [1:0] nx, fs;
        bit         nok, fok;
        find_slot(m_sel, 1, m, nx, nok);
        find_slot(2'd0, 0, m, fs, fok);
        m_ack = 0;
        m_fd  = 0;
        case (m_st)
            M_IDLE: begin
                if (r) begin
                    if (fok) begin
                        m_st = M_ACT; m_sel = fs; m_cnt = 0; m_step = 0;
                    end
                end else if (s && nok) begin
                    m_fd = (nx <= m_sel);
                    m_st = M_ACT; m_sel = nx; m_cnt = 0; m_step = 1;
                end
            end
            M_ACT: begin
                if (m_cnt == PRESCALE - 1) begin
                    m_cnt = 0;
                    if (m_step) begin
                        m_st = M_IDLE; m_ack = 1;
                    end else if (r && nok) begin
                        if (GAP > 0) begin
                            m_st = M_BLANK; m_pend = nx;
                        end else begin
                            m_fd = (nx <= m_sel); m_sel = nx;
                        end
                    end else begin
                        m_st = M_IDLE;
                    end
                end else begin
                    m_cnt++;
                end
            end
            default: begin
                if (m_cnt == BLANK_CYCLES - 1) begin
                    m_fd = (m_pend <= m_sel); m_sel = m_pend;
                    m_st = M_ACT; m_cnt = 0;
                end else begin
                    m_cnt++;
                end
            end
        endcase
    endtask

    // ---------------- driver tasks ----------------
    // Drive one cycle of inputs at the falling edge, push the expected
    // word, then pop and compare just after the rising edge.
    task automatic apply(input string name, input logic r, input logic s,
                         input logic [3:0] m, input logic [4:0] expv);
        logic [4:0] want;
        @(negedge clk);
        run = r; step_req = s; mask = m;
        exp_q.push_back(expv);
        @(posedge clk);
        #1;
        want = exp_q.pop_front();
        check(name, {3'b000, E, B, A, step_ack, frame_done}, {3'b000, want});
    endtask

    task automatic apply_model(input string name, input logic r, input logic s,
                               input logic [3:0] m);
        model_step(r, s, m);
        apply(name, r, s, m, {(m_st == M_ACT), m_sel, m_ack, m_fd});
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; run = 1'b0; step_req = 1'b0; mask = 4'b0000;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    // ---------------- stimulus tables ----------------
    typedef struct {
        logic       run;
        logic       step;
        logic [3:0] mask;
        logic [4:0] exp;   // {E, B, A, step_ack, frame_done}
    } vec_t;

    typedef struct {
        logic       run;
        logic       step;
        logic [3:0] mask;
        int         ncyc;
        bit         rnd;
    } seg_t;

    vec_t vt[18];
    seg_t segs[8];

    initial begin
        int guard;
        int per;
        int zeros;
        logic r_l, s_l;
        logic [3:0] m_l;

        // step mode from reset: two steps, masked-out attempt, wrap step,
        // step_req ignored while ACTIVE, run with everything masked
        vt[0]  = '{1'b0, 1'b0, 4'b0000, 5'b00000};
        vt[1]  = '{1'b0, 1'b1, 4'b0000, 5'b10100};
        vt[2]  = '{1'b0, 1'b0, 4'b0000, 5'b10100};
        vt[3]  = '{1'b0, 1'b0, 4'b0000, 5'b10100};
        vt[4]  = '{1'b0, 1'b0, 4'b0000, 5'b10100};
        vt[5]  = '{1'b0, 1'b0, 4'b0000, 5'b00110};
        vt[6]  = '{1'b0, 1'b1, 4'b0000, 5'b11000};
        vt[7]  = '{1'b0, 1'b0, 4'b0000, 5'b11000};
        vt[8]  = '{1'b0, 1'b0, 4'b0000, 5'b11000};
        vt[9]  = '{1'b0, 1'b0, 4'b0000, 5'b11000};
        vt[10] = '{1'b0, 1'b0, 4'b0000, 5'b01010};
        vt[11] = '{1'b0, 1'b1, 4'b1111, 5'b01000};
        vt[12] = '{1'b0, 1'b1, 4'b1000, 5'b10001};
        vt[13] = '{1'b0, 1'b1, 4'b1000, 5'b10000};
        vt[14] = '{1'b0, 1'b0, 4'b1000, 5'b10000};
        vt[15] = '{1'b0, 1'b0, 4'b1000, 5'b10000};
        vt[16] = '{1'b0, 1'b0, 4'b1000, 5'b00010};
        vt[17] = '{1'b1, 1'b1, 4'b1111, 5'b00000};

        segs[0] = '{1'b1, 1'b0, 4'b0000, 60, 1'b0};  // full scan
        segs[1] = '{1'b1, 1'b0, 4'b1010, 40, 1'b0};  // slots 0,2 only
        segs[2] = '{1'b0, 1'b0, 4'b0000, 12, 1'b0};  // run drops mid-slot
        segs[3] = '{1'b1, 1'b0, 4'b1110, 20, 1'b0};  // single slot
        segs[4] = '{1'b0, 1'b0, 4'b0000, 10, 1'b0};
        segs[5] = '{1'b1, 1'b1, 4'b1111, 50, 1'b0};  // all masked
        segs[6] = '{1'b0, 1'b1, 4'b1111, 5,  1'b0};  // step with no slot
        segs[7] = '{1'b0, 1'b0, 4'b0000, 400, 1'b1}; // random mix

        // ---- reset state ----
        model_reset();
        #3;
        check("reset_out", {3'b000, E, B, A, step_ack, frame_done}, 8'h00);
        do_reset();

        // ---- literal vectors ----
        for (int i = 0; i < 18; i++) begin
            apply($sformatf("vec%0d", i), vt[i].run, vt[i].step, vt[i].mask, vt[i].exp);
        end

        // ---- asynchronous reset during ACTIVE with sel=2 ----
        do_reset();
        run = 1'b1;
        guard = 0;
        while (!(E && !A && B) && guard < 100) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check("reach_sel2", {7'd0, guard < 100}, 8'h01);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst", {3'b000, E, B, A, step_ack, frame_done}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        run = 1'b1;
        @(posedge clk);
        #1;
        check("restart_sel0", {5'd0, E, B, A}, 8'h04);

        // ---- model-driven segments ----
        do_reset();
        r_l = 1'b0; s_l = 1'b0; m_l = 4'b0000;
        for (int sg = 0; sg < 8; sg++) begin
            for (int c = 0; c < segs[sg].ncyc; c++) begin
                if (segs[sg].rnd) begin
                    if ($urandom_range(0, 15) == 0) r_l = ~r_l;
                    s_l = ($urandom_range(0, 5) == 0);
                    if ($urandom_range(0, 9) == 0) m_l = 4'($urandom_range(0, 15));
                end else begin
                    r_l = segs[sg].run; s_l = segs[sg].step; m_l = segs[sg].mask;
                end
                apply_model($sformatf("seg%0d_c%0d", sg, c), r_l, s_l, m_l);
            end
        end

        // ---- frame period and enable gaps ----
        do_reset();
        run = 1'b1;
        mask = 4'b0000;
        guard = 0;
        while (!frame_done && guard < 100) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check("first_frame", {7'd0, guard < 100}, 8'h01);
        per = 0;
        zeros = 0;
        do begin
            @(posedge clk);
            #1;
            per++;
            if (!E) zeros++;
        end while (!frame_done && per < 200);
        check("frame_period", 8'(per), 8'(FRAME));
        check("e_low_cycles", 8'(zeros), 8'(4 * GAP));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Hard stop in case something above stalls.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/decoder_scan_sequencer.md
DECODER_SCAN_SEQUENCER -- requirements
Module: decoder_scan_sequencer

Interface
REQ-001 SHALL have parameter PRESCALE, default 4: number of clock cycles each slot is enabled (legal range 1..255).
REQ-002 SHALL have parameter BLANK_CYCLES, default 1: number of disabled cycles between slots when SCAN_BLANK_EN is defined (legal range 1..255).
REQ-003 SHALL use one clock and an asynchronous active-low reset. Ports:
- clk  in  1: rising-edge clock.
- rst_n  in  1: asynchronous active-low reset.
- run  in  1: level input; 1 = free-running scan.
- step_req  in  1: request to show one slot (used when run=0).
- mask  in  4: bit i = 1 means slot i is skipped.
- A  out  1: select LSB, drives the downstream 2-to-4 decoder.
- B  out  1: select MSB.
- E  out  1: decoder enable.
- step_ack  out  1: one-cycle pulse when a step completes.
- frame_done  out  1: one-cycle pulse on select wrap.

Function
REQ-004 SHALL hold a registered 2-bit select sel, with A=sel[0] and B=sel[1]. All outputs SHALL be registered.
REQ-005 SHALL have the states IDLE (E=0), ACTIVE (E=1) and BLANK (E=0).
REQ-006 next(sel) SHALL be the first slot with mask bit 0 in the search order sel+1, sel+2, sel+3, sel (modulo 4). If every mask bit is 1, there is no next slot.
REQ-007 IDLE, when run=1 is sampled and some mask bit is 0: the FSM SHALL enter ACTIVE next cycle with sel = first unmasked slot searching upward from 0. Latency from run sampled to E=1 SHALL be 1 cycle.
REQ-008 IDLE, when run=0 and step_req=1 are sampled and a next slot exists: the FSM SHALL set sel=next(sel) and enter ACTIVE in step mode.
REQ-009 ACTIVE SHALL hold E=1 for exactly PRESCALE cycles, counted by an internal counter that is cleared on entry.
REQ-010 At the end of an ACTIVE slot in step mode: the FSM SHALL go to IDLE and pulse step_ack in the first IDLE cycle. sel SHALL be unchanged.
REQ-011 At the end of an ACTIVE slot in run mode with run=1 and a next slot existing: the FSM SHALL advance to BLANK, or directly to ACTIVE (see REQ-019). It SHALL then load sel=next(sel) on the cycle E rises again.
REQ-012 At the end of an ACTIVE slot, if run=0 or all mask bits are 1: the FSM SHALL go to IDLE, with no step_ack and sel held.
REQ-013 BLANK SHALL last exactly BLANK_CYCLES cycles and then enter ACTIVE.
REQ-014 frame_done SHALL pulse for 1 cycle, coincident with the sel update, whenever the new sel is less than or equal to the old sel. With a single unmasked slot, it therefore pulses every slot.
REQ-015 Deasserting run mid-slot SHALL NOT truncate the slot: the current ACTIVE (and any BLANK) completes first.
REQ-016 step_req SHALL be ignored outside IDLE and whenever run=1. run takes priority if run and step_req are sampled together.
REQ-017 mask SHALL be sampled only when next(sel) is evaluated. A mask change mid-slot SHALL NOT affect the current slot.

Reset
REQ-018 While rst_n=0, the block SHALL force immediately, independent of clk: state=IDLE, sel=0 (A=0, B=0), E=0, step_ack=0, frame_done=0, and all counters 0. Operation SHALL resume on the first clk edge after rst_n rises.

Configuration
REQ-019 Macro SCAN_BLANK_EN:
- Defined: the BLANK state is used between run-mode slots.
- Undefined: there is no BLANK state. ACTIVE goes directly to ACTIVE with the new sel, so E stays 1 continuously across slots. BLANK_CYCLES is unused.
- Step-mode behaviour SHALL be identical in both builds.

Verification
REQ-020 Build with SCAN_BLANK_EN, PRESCALE=4, BLANK_CYCLES=1, mask=0000, run=1 held:
- sel sequence 0,1,2,3,0, each with E=1 for 4 cycles then E=0 for 1 cycle.
- Frame period 20 cycles.
- frame_done pulses once per frame, at the 3->0 update.
REQ-021 mask=1010, run=1: sel alternates 0,2,0,2. frame_done pulses on each 2->0 update. Slots 1 and 3 are never enabled.
REQ-022 run=0, sel=0, mask=0000, one-cycle step_req:
- sel=1 with E=1 for exactly 4 cycles.
- step_ack pulses the next cycle.
- A second step_req gives sel=2.
REQ-023 mask=1111, run=1 for 50 cycles: E stays 0 and sel stays 0. A step_req gives no step_ack.
REQ-024 rst_n pulsed low between clock edges during ACTIVE with sel=2: E, A and B go to 0 immediately without a clk edge. After release with run=1, the scan restarts at sel=0.
REQ-025 Build without SCAN_BLANK_EN, PRESCALE=4, mask=0000, run=1: E stays 1 continuously, sel changes every 4 cycles, and the frame period is 16 cycles.
